ex_branch_ctrl: RTL and testbench
=================================

Name: ex_branch_ctrl

Overview:
- Control block beside the execute stage of the 16-bit pipelined core.
- Holds the architectural V/Z/N flag register, which is written from the ALU flag outputs.
- Resolves conditional branches and jumps for the instruction currently in EX, drives PC redirect and younger-stage flushes, and sequences halt drain.
- Sits between the ID/EX pipeline register, the EX datapath (branch/jump target adders, ALU flags) and the IF PC mux.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect (squashes IF/ID and ID/EX slots).
- DRAIN_CYCLES, 2, cycles after HLT reaches EX before halted_o asserts (lets MEM/WB retire).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- stall_i  input  1  pipeline-wide stall; EX contents held
- ex_valid_i  input  1  EX slot holds a real (non-bubble) instruction
- is_br_i  input  1  EX instruction is a conditional branch
- is_jmp_i  input  1  EX instruction is an unconditional jump
- is_hlt_i  input  1  EX instruction is HLT
- cond_i  input  3  branch condition code
- flag_we_i  input  3  per-flag write enable {V,Z,N} from decode
- alu_v_i, alu_z_i, alu_n_i  input  1 each  ALU flag outputs this cycle
- br_target_i  input  16  branch target from EX target adder
- jmp_target_i  input  16  jump target from EX jump-address block
- flags_o  output  3  registered {V,Z,N}
- redirect_o  output  1  one-cycle PC load strobe
- target_o  output  16  PC value to load when redirect_o=1
- flush_o  output  1  squash IF/ID and ID/EX contents
- freeze_fetch_o  output  1  PC hold during halt drain and halted
- halted_o  output  1  core halted

Behaviour:
- Reset (async, rst_n=0): flags_o=000, redirect_o=0, target_o=0, flush_o=0, freeze_fetch_o=0, halted_o=0, FSM=RUN, counter=0.
- An instruction is "live" when ex_valid_i=1, stall_i=0, FSM=RUN and flush_o=0.
- Flags:
  - On a live cycle, each flag whose flag_we_i bit is set loads the matching alu_*_i at the clock edge.
  - Other flags hold. Flags never change when the cycle is not live.
- Condition evaluation is combinational on the registered flags_o, before this cycle's update:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: !N
  - 101 LTE: N|Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Redirect:
  - A live branch with a true condition, or a live jump, registers redirect_o=1 for exactly one cycle on the next edge.
  - target_o = br_target_i for a branch, jmp_target_i for a jump. Jump has priority if both is_br_i and is_jmp_i are set.
  - target_o holds its last value otherwise. A not-taken branch has no effect.
- FSM states: RUN, FLUSH, DRAIN, HALTED.
  - RUN -> FLUSH on a taken redirect: flush_o=1 for FLUSH_CYCLES cycles, counting only non-stalled cycles. FLUSH -> RUN when the count expires.
  - A redirect or HLT arriving during FLUSH is ignored, because that instruction is being squashed.
  - RUN -> DRAIN on a live HLT: freeze_fetch_o=1 and flush_o=1 for one cycle (discard younger fetches). Counter runs DRAIN_CYCLES non-stalled cycles.
  - DRAIN -> HALTED when the count expires: halted_o=1 and freeze_fetch_o=1 remain until reset.
  - HLT has priority over branch/jump if flagged together.
- stall_i=1 freezes the FSM, counter and all outputs except redirect_o, which is still a single-cycle pulse; a pending redirect is not repeated.
- Simultaneous flag write and branch evaluation in the same cycle use the old flags.
- Reset mid-FLUSH or mid-DRAIN returns to RUN with all outputs cleared.

Decomposition:
- Shared package:
  - cond code constants (COND_NE..COND_UNCOND)
  - FSM state enum
  - flag bit indices (FLG_V=2, FLG_Z=1, FLG_N=0)
- One natural sub-module: br_cond_eval (combinational cond_i + flags -> taken). Used here and reusable by a future ID-stage predictor.

Test Plan:
- Reset, then write Z=1 via flag_we=010 on a live op; next cycle EQ branch with br_target=0x0040 -> redirect_o pulses once with target_o=0x0040, flush_o high 2 cycles, flags_o=010.
- flags_o=001 (N), GT branch -> no redirect, no flush; LTE branch next -> redirect to br_target=0x0123.
- Same-cycle ADD (flag_we=111, alu_z=1) and EQ branch with old Z=0 -> not taken; flags_o=010 afterwards.
- Jump to 0x1FFE, then stall_i=1 for 3 cycles during FLUSH -> flush_o stays high 2 non-stalled cycles (5 total); the branch in the squashed slot causes no redirect.
- Live HLT -> freeze_fetch_o=1 immediately; halted_o=1 exactly 2 non-stalled cycles later; a later jump is ignored.
- Assert rst_n=0 mid-DRAIN -> all outputs 0 asynchronously; after release an OVFL branch with V=0 is not taken.

Source files
------------

// File: rtl/ex_branch_ctrl_pkg.sv
// ex_branch_ctrl_pkg: shared condition codes, control FSM states and flag bit
// positions for the EX-stage branch controller and its helpers.
package ex_branch_ctrl_pkg;
    localparam logic [2:0] COND_NE     = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_LT     = 3'd3;
    localparam logic [2:0] COND_GTE    = 3'd4;
    localparam logic [2:0] COND_LTE    = 3'd5;
    localparam logic [2:0] COND_OVFL   = 3'd6;
    localparam logic [2:0] COND_UNCOND = 3'd7;

    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DRAIN, ST_HALTED} state_t;
endpackage

// File: rtl/ex_branch_ctrl_br_cond_eval.sv
// br_cond_eval: combinational branch-condition check of a 3-bit condition
// code against a {V,Z,N} flag vector.
module br_cond_eval
    import ex_branch_ctrl_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [2:0] flags_i,
    output logic       taken_o
);
    logic w_v, w_z, w_n;

    assign w_v = flags_i[FLG_V];
    assign w_z = flags_i[FLG_Z];
    assign w_n = flags_i[FLG_N];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_NE:     taken_o = ~w_z;
            COND_EQ:     taken_o = w_z;
            COND_GT:     taken_o = ~w_z & ~w_n;
            COND_LT:     taken_o = w_n;
            COND_GTE:    taken_o = ~w_n;
            COND_LTE:    taken_o = w_n | w_z;
            COND_OVFL:   taken_o = w_v;
            COND_UNCOND: taken_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/ex_branch_ctrl.sv
// ex_branch_ctrl: EX-stage flag register, branch/jump resolution, PC redirect,
// younger-stage flush and halt drain sequencing.
module ex_branch_ctrl
    import ex_branch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        is_br_i,
    input  logic        is_jmp_i,
    input  logic        is_hlt_i,
    input  logic [2:0]  cond_i,
    input  logic [2:0]  flag_we_i,
    input  logic        alu_v_i,
    input  logic        alu_z_i,
    input  logic        alu_n_i,
    input  logic [15:0] br_target_i,
    input  logic [15:0] jmp_target_i,
    output logic [2:0]  flags_o,
    output logic        redirect_o,
    output logic [15:0] target_o,
    output logic        flush_o,
    output logic        freeze_fetch_o,
    output logic        halted_o
);
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cond, w_live, w_redir;
    logic [2:0]       w_alu;

    br_cond_eval u_cond (
        .cond_i  (cond_i),
        .flags_i (flags_o),
        .taken_o (w_cond)
    );

    // A slot is squashed while flushing, so only RUN with no flush pending is live.
    assign w_live  = ex_valid_i & ~stall_i & (r_state == ST_RUN) & ~flush_o;
    assign w_redir = w_live & ~is_hlt_i & (is_jmp_i | (is_br_i & w_cond));
    assign w_alu   = {alu_v_i, alu_z_i, alu_n_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_cnt          <= '0;
            flags_o        <= '0;
            redirect_o     <= 1'b0;
            target_o       <= '0;
            flush_o        <= 1'b0;
            freeze_fetch_o <= 1'b0;
            halted_o       <= 1'b0;
        end else begin
            redirect_o <= w_redir;
            if (w_live)
                flags_o <= (flags_o & ~flag_we_i) | (w_alu & flag_we_i);
            if (!stall_i) begin
                case (r_state)
                    ST_RUN: begin
                        if (w_live && is_hlt_i) begin
                            r_state        <= ST_DRAIN;
                            r_cnt          <= CNT_W'(DRAIN_CYCLES - 1);
                            flush_o        <= 1'b1;
                            freeze_fetch_o <= 1'b1;
                        end else if (w_redir) begin
                            r_state  <= ST_FLUSH;
                            r_cnt    <= CNT_W'(FLUSH_CYCLES - 1);
                            flush_o  <= 1'b1;
                            target_o <= is_jmp_i ? jmp_target_i : br_target_i;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_RUN;
                            flush_o <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        flush_o <= 1'b0;
                        if (r_cnt == '0) begin
                            r_state  <= ST_HALTED;
                            halted_o <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_branch_ctrl.sv
// tb_ex_branch_ctrl: directed plan plus randomized traffic for ex_branch_ctrl,
// checked against a behavioural model of the flag/redirect/flush/halt rules.
module tb_ex_branch_ctrl;
    localparam int FLUSH_N = 2;
    localparam int DRAIN_N = 2;

    logic        clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, ex_valid_i = 1'b0;
    logic        is_br_i = 1'b0, is_jmp_i = 1'b0, is_hlt_i = 1'b0;
    logic [2:0]  cond_i = '0, flag_we_i = '0;
    logic        alu_v_i = 1'b0, alu_z_i = 1'b0, alu_n_i = 1'b0;
    logic [15:0] br_target_i = '0, jmp_target_i = '0;
    logic [2:0]  flags_o;
    logic        redirect_o, flush_o, freeze_fetch_o, halted_o;
    logic [15:0] target_o;

    int n_vec = 0, n_bad = 0;

    logic [2:0]  m_flags;
    logic        m_redir, m_flush, m_freeze, m_halted;
    logic [15:0] m_target;
    int          m_mode, m_left;

    ex_branch_ctrl #(.FLUSH_CYCLES(FLUSH_N), .DRAIN_CYCLES(DRAIN_N)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .is_br_i(is_br_i), .is_jmp_i(is_jmp_i), .is_hlt_i(is_hlt_i),
        .cond_i(cond_i), .flag_we_i(flag_we_i),
        .alu_v_i(alu_v_i), .alu_z_i(alu_z_i), .alu_n_i(alu_n_i),
        .br_target_i(br_target_i), .jmp_target_i(jmp_target_i),
        .flags_o(flags_o), .redirect_o(redirect_o), .target_o(target_o),
        .flush_o(flush_o), .freeze_fetch_o(freeze_fetch_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic v, z, n;
        v = f[2]; z = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags"},  16'(flags_o),        16'(m_flags));
        chk({tag, ".redir"},  16'(redirect_o),     16'(m_redir));
        chk({tag, ".target"}, target_o,            m_target);
        chk({tag, ".flush"},  16'(flush_o),        16'(m_flush));
        chk({tag, ".freeze"}, 16'(freeze_fetch_o), 16'(m_freeze));
        chk({tag, ".halted"}, 16'(halted_o),       16'(m_halted));
    endtask

    task automatic model_reset;
        m_flags = '0; m_redir = 0; m_flush = 0; m_freeze = 0; m_halted = 0;
        m_target = '0; m_mode = 0; m_left = 0;
    endtask

    // mode: 0 running, 1 flushing, 2 draining, 3 halted
    task automatic model_step;
        logic live;
        live = ex_valid_i && !stall_i && m_mode == 0 && !m_flush;
        m_redir = live && !is_hlt_i && (is_jmp_i || (is_br_i && cond_ok(cond_i, m_flags)));
        if (!stall_i && m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin m_mode = 0; m_flush = 0; end
        end
        if (!stall_i && m_mode == 2) begin
            m_flush = 0;
            m_left--;
            if (m_left == 0) begin m_mode = 3; m_halted = 1; end
        end
        if (live && is_hlt_i) begin
            m_mode = 2; m_left = DRAIN_N; m_flush = 1; m_freeze = 1;
        end else if (m_redir) begin
            m_mode = 1; m_left = FLUSH_N; m_flush = 1;
            m_target = is_jmp_i ? jmp_target_i : br_target_i;
        end
        if (live)
            m_flags = (m_flags & ~flag_we_i) | ({alu_v_i, alu_z_i, alu_n_i} & flag_we_i);
    endtask

    task automatic step(input string tag);
        model_step;
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic op(input string tag, input logic v, input logic br, input logic jmp,
                      input logic hlt, input logic [2:0] c, input logic [2:0] we,
                      input logic [2:0] alu, input logic [15:0] bt, input logic [15:0] jt,
                      input logic st);
        ex_valid_i = v; is_br_i = br; is_jmp_i = jmp; is_hlt_i = hlt;
        cond_i = c; flag_we_i = we; {alu_v_i, alu_z_i, alu_n_i} = alu;
        br_target_i = bt; jmp_target_i = jt; stall_i = st;
        step(tag);
    endtask

    initial begin
        #2;
        do_reset("reset");
        op("setz", 1, 0, 0, 0, 3'd0, 3'b010, 3'b010, 16'h0, 16'h0, 0);
        chk("setz.flags", 16'(flags_o), 16'h2);
        op("eq", 1, 1, 0, 0, 3'd1, 3'b000, 3'b000, 16'h0040, 16'h0, 0);
        chk("eq.redir", 16'(redirect_o), 16'h1);
        chk("eq.target", target_o, 16'h0040);
        op("eq_b1", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        chk("eq_b1.redir", 16'(redirect_o), 16'h0);
        chk("eq_b1.flush", 16'(flush_o), 16'h1);
        op("eq_b2", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        chk("eq_b2.flush", 16'(flush_o), 16'h0);
        op("setn", 1, 0, 0, 0, 3'd0, 3'b111, 3'b001, 16'h0, 16'h0, 0);
        op("gt", 1, 1, 0, 0, 3'd2, 3'b000, 3'b000, 16'h0999, 16'h0, 0);
        chk("gt.redir", 16'(redirect_o), 16'h0);
        op("lte", 1, 1, 0, 0, 3'd5, 3'b000, 3'b000, 16'h0123, 16'h0, 0);
        chk("lte.target", target_o, 16'h0123);
        op("lte_b1", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        op("lte_b2", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        op("addeq", 1, 1, 0, 0, 3'd1, 3'b111, 3'b010, 16'h0555, 16'h0, 0);
        chk("addeq.redir", 16'(redirect_o), 16'h0);
        chk("addeq.flags", 16'(flags_o), 16'h2);
        op("jmp", 1, 0, 1, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h1FFE, 0);
        chk("jmp.target", target_o, 16'h1FFE);
        for (int i = 0; i < 3; i++) begin
            op("stall", 1, 1, 0, 0, 3'd7, 3'b000, 3'b000, 16'h0777, 16'h0, 1);
            chk("stall.flush", 16'(flush_o), 16'h1);
        end
        op("sq1", 1, 1, 0, 0, 3'd7, 3'b000, 3'b000, 16'h0777, 16'h0, 0);
        chk("sq1.flush", 16'(flush_o), 16'h1);
        op("sq2", 1, 1, 0, 0, 3'd7, 3'b000, 3'b000, 16'h0777, 16'h0, 0);
        chk("sq2.flush", 16'(flush_o), 16'h0);
        chk("sq2.redir", 16'(redirect_o), 16'h0);
        op("hlt", 1, 0, 0, 1, 3'd7, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        chk("hlt.freeze", 16'(freeze_fetch_o), 16'h1);
        op("drain1", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        chk("drain1.halted", 16'(halted_o), 16'h0);
        op("drain2", 0, 0, 0, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        chk("drain2.halted", 16'(halted_o), 16'h1);
        op("late_jmp", 1, 0, 1, 0, 3'd0, 3'b000, 3'b000, 16'h0, 16'h2222, 0);
        chk("late_jmp.target", target_o, 16'h1FFE);
        do_reset("reset2");
        op("hlt2", 1, 0, 0, 1, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 0);
        do_reset("mid_drain");
        op("ovfl", 1, 1, 0, 0, 3'd6, 3'b000, 3'b000, 16'h0ABC, 16'h0, 0);
        chk("ovfl.redir", 16'(redirect_o), 16'h0);
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(3) == 0) begin
                do_reset("rnd_rst");
            end else begin
                ex_valid_i   = $urandom_range(3) != 0;
                is_br_i      = $urandom_range(1) == 1;
                is_jmp_i     = $urandom_range(4) == 0;
                is_hlt_i     = $urandom_range(24) == 0;
                cond_i       = 3'($urandom);
                flag_we_i    = 3'($urandom);
                {alu_v_i, alu_z_i, alu_n_i} = 3'($urandom);
                br_target_i  = 16'($urandom);
                jmp_target_i = 16'($urandom);
                stall_i      = $urandom_range(3) == 0;
                step("rnd");
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
